// File: rtl/inv_subbytes_seq.sv
// Sequential inverse SubBytes: streams one 32-bit word per cycle through an
// external combinational inverse S-box and returns the 128-bit result with a handshake.
module inv_subbytes_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic [31:0]  sbox_word,
   input  logic [31:0]  sbox_result,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic [31:0] words_reg  [4];
   logic [31:0] words_next [4];
   logic [31:0] in_words   [4];

   // Word 0 sits in the most significant 32 bits on both the input and output side.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_word_map
         assign in_words[gi]                       = in_state[127-32*gi -: 32];
         assign out_state[127-32*gi -: 32]         = words_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            words_reg[i] <= 32'h0;
         end
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         for (int i = 0; i < 4; i++) begin
            words_reg[i] <= words_next[i];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      for (int i = 0; i < 4; i++) begin
         words_next[i] = words_reg[i];
      end
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               for (int i = 0; i < 4; i++) begin
                  words_next[i] = in_words[i];
               end
               cnt_next   = 2'd0;
               state_next = SUB;
            end
         end
         SUB: begin
            // The S-box result for the current word is written back in place.
            words_next[cnt_reg] = sbox_result;
            cnt_next            = cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign out_valid = (state_reg == DONE);
   assign sbox_word = (state_reg == SUB) ? words_reg[cnt_reg] : 32'h0;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Directed bench for inv_subbytes_seq with a reference AES inverse S-box on the
// sbox_word/sbox_result port.
module tb_inv_subbytes_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [31:0]  sbox_word;
   logic [31:0]  sbox_result;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   int n_assert = 0;
   int n_fail   = 0;

   inv_subbytes_seq dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_state    (in_state),
      .sbox_word   (sbox_word),
      .sbox_result (sbox_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_state   (out_state),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] inv_row(input logic [3:0] r);
      case (r)
         4'h0: inv_row = 128'h52096ad5_3036a538_bf40a39e_81f3d7fb;
         4'h1: inv_row = 128'h7ce33982_9b2fff87_348e4344_c4dee9cb;
         4'h2: inv_row = 128'h547b9432_a6c2233d_ee4c950b_42fac34e;
         4'h3: inv_row = 128'h082ea166_28d924b2_765ba249_6d8bd125;
         4'h4: inv_row = 128'h72f8f664_86689816_d4a45ccc_5d65b692;
         4'h5: inv_row = 128'h6c704850_fdedb9da_5e154657_a78d9d84;
         4'h6: inv_row = 128'h90d8ab00_8cbcd30a_f7e45805_b8b34506;
         4'h7: inv_row = 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b;
         4'h8: inv_row = 128'h3a911141_4f67dcea_97f2cfce_f0b4e673;
         4'h9: inv_row = 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e;
         4'ha: inv_row = 128'h47f11a71_1d29c589_6fb7620e_aa18be1b;
         4'hb: inv_row = 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4;
         4'hc: inv_row = 128'h1fdda833_8807c731_b1121059_2780ec5f;
         4'hd: inv_row = 128'h60517fa9_19b54a0d_2de57a9f_93c99cef;
         4'he: inv_row = 128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961;
         default: inv_row = 128'h172b047e_ba77d626_e169146f_55210c7d;
      endcase
   endfunction

   function automatic logic [7:0] inv_byte(input logic [7:0] b);
      logic [127:0] row;
      row = inv_row(b[7:4]);
      inv_byte = row[127-8*b[3:0] -: 8];
   endfunction

   always_comb begin
      sbox_result = {inv_byte(sbox_word[31:24]), inv_byte(sbox_word[23:16]),
                     inv_byte(sbox_word[15:8]),  inv_byte(sbox_word[7:0])};
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept v, check the per-cycle S-box word sequence and the final result.
   task automatic run_vec(input string tag, input logic [127:0] v, input logic [127:0] e,
                          input logic hold);
      in_valid  = 1'b1;
      in_state  = v;
      out_ready = 1'b0;
      step();
      in_valid  = 1'b0;
      in_state  = {4{$urandom()}};
      chk({tag, " busy"}, busy, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s sbox_word%0d", tag, k), sbox_word, v[127-32*k -: 32]);
         chk($sformatf("%s early_valid%0d", tag, k), out_valid, 1'b0);
         step();
      end
      chk({tag, " out_valid"}, out_valid, 1'b1);
      chk({tag, " out_state"}, out_state, e);
      chk({tag, " sbox_idle"}, sbox_word, 32'h0);
      if (!hold) begin
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         chk({tag, " back_idle"}, in_ready, 1'b1);
      end
      $display("vector %s in=%h out=%h", tag, v, out_state);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_state  = 128'h0;
      out_ready = 1'b0;
      #3;
      chk("rst in_ready",  in_ready,  1'b1);
      chk("rst out_valid", out_valid, 1'b0);
      chk("rst busy",      busy,      1'b0);
      chk("rst sbox_word", sbox_word, 32'h0);
      chk("rst out_state", out_state, 128'h0);
      step();
      step();
      rst = 1'b0;

      // IDLE with in_valid low stays put.
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      chk("idle hold in_ready", in_ready, 1'b1);
      chk("idle hold busy", busy, 1'b0);

      run_vec("v63", {4{32'h63636363}}, 128'h0, 1'b0);
      run_vec("v00", 128'h0, {4{32'h52525252}}, 1'b0);
      run_vec("vinc", 128'h00010203_04050607_08090a0b_0c0d0e0f,
              128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 1'b0);

      // Stall in DONE for 10 cycles.
      run_vec("vdec", 128'h0f0e0d0c_0b0a0908_07060504_03020100,
              128'hfbd7f381_9ea340bf_38a53630_d56a0952, 1'b1);
      in_valid = 1'b1;
      in_state = 128'h0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("stall valid%0d", i), out_valid, 1'b1);
         chk($sformatf("stall state%0d", i), out_state, 128'hfbd7f381_9ea340bf_38a53630_d56a0952);
         chk($sformatf("stall in_ready%0d", i), in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("release in_ready", in_ready, 1'b1);
      chk("release out_valid", out_valid, 1'b0);
      $display("stall 10 cycles then release");

      // in_valid held high with changing data, out_ready tied high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = {4{32'h63636363}};
      step();
      for (int i = 0; i < 4; i++) begin
         in_state = {4{$urandom()}};
         chk($sformatf("b2b A busy%0d", i), busy, 1'b1);
         step();
      end
      chk("b2b A out_valid", out_valid, 1'b1);
      chk("b2b A out_state", out_state, 128'h0);
      in_state = 128'h00010203_04050607_08090a0b_0c0d0e0f;
      step();
      chk("b2b gap in_ready", in_ready, 1'b1);
      in_state = 128'h0;
      step();
      for (int i = 0; i < 4; i++) begin
         in_state = {4{$urandom()}};
         chk($sformatf("b2b B busy%0d", i), busy, 1'b1);
         step();
      end
      chk("b2b B out_valid", out_valid, 1'b1);
      chk("b2b B out_state", out_state, {4{32'h52525252}});
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      chk("b2b end in_ready", in_ready, 1'b1);
      $display("back-to-back accepts six cycles apart");

      // Reset in the middle of SUB at cnt = 2.
      in_valid = 1'b1;
      in_state = 128'h00010203_04050607_08090a0b_0c0d0e0f;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("midrst sbox_word", sbox_word, 32'h08090a0b);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst in_ready",  in_ready,  1'b1);
      chk("midrst out_valid", out_valid, 1'b0);
      chk("midrst busy",      busy,      1'b0);
      chk("midrst sbox_word", sbox_word, 32'h0);
      chk("midrst out_state", out_state, 128'h0);
      step();
      chk("midrst held valid", out_valid, 1'b0);
      rst = 1'b0;
      step();
      chk("postrst valid", out_valid, 1'b0);
      $display("reset in SUB discarded in-flight state");
      run_vec("postrst", 128'h0, {4{32'h52525252}}, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/inv_subbytes_seq.md
INV_SUBBYTES_SEQ -- requirements
Module: inv_subbytes_seq

Interface
REQ-001 The block SHALL have no parameters; the state width is fixed at 128 bits and the S-box path width at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  a 128-bit state is offered on in_state.
REQ-005 in_ready  output  1  the block can accept a state this cycle.
REQ-006 in_state  input  128  state to be inverse-substituted; word 0 = bits 127:96, word 3 = bits 31:0.
REQ-007 sbox_word  output  32  word presented to the external combinational 32-bit inverse S-box.
REQ-008 sbox_result  input  32  inverse S-box output for sbox_word, valid in the same cycle.
REQ-009 out_valid  output  1  out_state holds a completed result.
REQ-010 out_ready  input  1  the consumer takes the result this cycle.
REQ-011 out_state  output  128  inverse-SubBytes result, same word ordering as in_state.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SUB and DONE, with a 2-bit word counter cnt.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL equal (state != IDLE); out_valid SHALL be 1 only in DONE.
REQ-015 An accept occurs when in_valid and in_ready are both 1 at a rising edge; on accept, in_state SHALL be loaded into a 128-bit buffer, cnt SHALL be set to 0 and the FSM SHALL move to SUB.
REQ-016 In IDLE with in_valid low, the FSM SHALL remain in IDLE and the buffer SHALL be unchanged.
REQ-017 In SUB, sbox_word SHALL equal buffer word[cnt], combinationally selected.
REQ-018 In SUB, at each edge, sbox_result SHALL be written into buffer word[cnt] and cnt SHALL increment by 1, wrapping from 3 to 0.
REQ-019 In SUB, the FSM SHALL move from SUB to DONE on the edge where cnt = 3.
REQ-020 Outside SUB, sbox_word SHALL be 32'h0.
REQ-021 out_valid SHALL rise exactly 4 clock edges after the accept edge; all four words SHALL then be substituted.
REQ-022 out_state SHALL be driven directly from the buffer; its value is defined only while out_valid = 1, and it SHALL stay stable while out_valid = 1.
REQ-023 In DONE, the FSM SHALL go to IDLE on an edge with out_ready = 1; with out_ready = 0, it SHALL hold DONE and out_state indefinitely.
REQ-024 in_valid SHALL be ignored in SUB and DONE, with no queuing; the minimum spacing between accepts is 6 cycles.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 The block SHALL contain no S-box table; substitution comes only through sbox_word/sbox_result.

Reset
REQ-027 While rst is 1, the block SHALL immediately enter state IDLE with cnt = 0 and buffer = 128'h0.
REQ-028 While rst is 1, the outputs SHALL be in_ready = 1, out_valid = 0, busy = 0, sbox_word = 32'h0 and out_state = 128'h0.
REQ-029 Reset asserted in SUB or DONE SHALL discard the in-flight state with no output handshake; operation resumes in IDLE after rst deasserts.

Verification
REQ-030 With a reference inverse S-box attached, accept in_state = 128'h63636363_63636363_63636363_63636363 -> out_state = 128'h0, with out_valid high 4 edges after the accept.
REQ-031 Accept in_state = 128'h0 -> out_state = 128'h52525252_52525252_52525252_52525252; sbox_word sequence is 0,0,0,0, one word per SUB cycle.
REQ-032 Accept in_state = 128'h00010203_04050607_08090a0b_0c0d0e0f -> out_state = 128'h52096ad5_3036a538_bf40a39e_81f3d7fb; sbox_word shows words 0 to 3 in order.
REQ-033 Hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_state stay stable and in_ready = 0; pulse out_ready = 1 -> IDLE on the next edge.
REQ-034 Hold in_valid = 1 continuously with changing in_state -> only the in_state value present at each IDLE accept is processed; back-to-back accepts are 6 cycles apart with out_ready tied to 1.
REQ-035 Assert rst in the middle of SUB (cnt = 2) -> outputs immediately take the REQ-028 reset values with no out_valid pulse; the next accepted vector gives a correct result.
